// File: rtl/irq_encoder_148.sv
// irq_encoder_148: synchronized, edge-captured 8-to-3 priority encoder with valid/ack handshake
module irq_encoder_148 #(
  parameter int SYNC_STAGES = 2,
  parameter bit PRIO_HIGH = 1'b1
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] yn_i,
  input  logic       ei_n_i,
  input  logic       ack_i,
  output logic [2:0] code_o,
  output logic       valid_o,
  output logic       gs_n_o,
  output logic       eo_n_o,
  output logic       ovf_o
);
  typedef enum logic {IDLE, PRESENT} state_t;
  state_t state, state_n;
  logic [SYNC_STAGES-1:0][7:0] yn_sync;
  logic [SYNC_STAGES-1:0] ei_sync;
  logic [7:0] req_s, prev_req, rise, clr, pend, pend_n;
  logic [2:0] top;
  logic en_s, take, done;
  assign req_s = ~yn_sync[SYNC_STAGES-1];
  assign en_s = ~ei_sync[SYNC_STAGES-1];
  assign rise = req_s & ~prev_req;
  assign done = (state == PRESENT) && ack_i;
  assign take = (state == IDLE) && en_s && (|pend);
  assign clr = done ? (8'b1 << code_o) : 8'b0;
  assign pend_n = (pend & ~clr) | rise;
  assign valid_o = (state == PRESENT);
  // synchronizers idle high so nothing looks requested out of reset
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      yn_sync <= '1;
      ei_sync <= '1;
    end else begin
      yn_sync <= {yn_sync[SYNC_STAGES-2:0], yn_i};
      ei_sync <= {ei_sync[SYNC_STAGES-2:0], ei_n_i};
    end
  // highest-priority pending line; the last hit in scan order wins
  always_comb begin
    top = 3'd0;
    for (int k = 0; k < 8; k++)
      if (pend[PRIO_HIGH ? k : 7 - k]) top = PRIO_HIGH ? 3'(k) : 3'(7 - k);
  end
  // next state: leave IDLE on an enabled pending request, leave PRESENT on ack
  always_comb begin
    state_n = state;
    state_n = take ? PRESENT : done ? IDLE : state;
  end
  // state register
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) state <= IDLE;
    else state <= state_n;
  // edge capture, pending set-wins-over-clear, overflow and cascade status
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      prev_req <= 8'b0;
      pend <= 8'b0;
      code_o <= 3'd0;
      ovf_o <= 1'b0;
      gs_n_o <= 1'b1;
      eo_n_o <= 1'b1;
    end else begin
      prev_req <= req_s;
      pend <= pend_n;
      code_o <= take ? top : code_o;
      ovf_o <= |(rise & pend & ~clr);
      gs_n_o <= ~(en_s & (|pend));
      eo_n_o <= ~(en_s & ~(|pend));
    end
endmodule

// File: tb/tb_irq_encoder_148.sv
// tb_irq_encoder_148: directed plus random checks of both priority orders against a behavioural model
module tb_irq_encoder_148;
  localparam int S = 2;
  logic clk = 1'b0, rst = 1'b1, ei = 1'b1, ack = 1'b0;
  logic [7:0] yn = 8'hFF;
  logic [2:0] code [2];
  logic valid [2], gs [2], eo [2], ovf [2];
  int n_chk = 0, n_fail = 0, ovf_cnt = 0;
  bit [7:0] yq[$];
  bit eq[$];
  bit [7:0] m_prev;
  bit [7:0] m_pend [2];
  bit [2:0] m_code [2];
  bit m_valid [2], m_gs [2], m_eo [2], m_ovf [2], pv [2];
  int seen [2][$];

  always #5 clk = ~clk;

  irq_encoder_148 #(.SYNC_STAGES(S), .PRIO_HIGH(1'b0)) u_lo (
    .clk_i(clk), .rst_i(rst), .yn_i(yn), .ei_n_i(ei), .ack_i(ack),
    .code_o(code[0]), .valid_o(valid[0]), .gs_n_o(gs[0]), .eo_n_o(eo[0]), .ovf_o(ovf[0]));
  irq_encoder_148 #(.SYNC_STAGES(S), .PRIO_HIGH(1'b1)) u_hi (
    .clk_i(clk), .rst_i(rst), .yn_i(yn), .ei_n_i(ei), .ack_i(ack),
    .code_o(code[1]), .valid_o(valid[1]), .gs_n_o(gs[1]), .eo_n_o(eo[1]), .ovf_o(ovf[1]));

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit [2:0] pick(input bit [7:0] p, input bit hi);
    pick = 3'd0;
    if (hi) begin
      for (int i = 7; i >= 0; i--) if (p[i]) return 3'(i);
    end else begin
      for (int i = 0; i < 8; i++) if (p[i]) return 3'(i);
    end
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic ack_pulse();
    ack = 1'b1;
    cyc(1);
    ack = 1'b0;
  endtask

  always @(posedge clk or posedge rst) begin
    bit [7:0] req, rise, clr;
    bit en;
    if (rst) begin
      yq.delete();
      eq.delete();
      repeat (S) begin
        yq.push_back(8'hFF);
        eq.push_back(1'b1);
      end
      m_prev = 8'h00;
      for (int m = 0; m < 2; m++) begin
        m_pend[m] = 8'h00; m_code[m] = 3'd0; m_valid[m] = 1'b0;
        m_gs[m] = 1'b1; m_eo[m] = 1'b1; m_ovf[m] = 1'b0;
      end
    end else begin
      req = ~yq[0];
      en = ~eq[0];
      void'(yq.pop_front());
      void'(eq.pop_front());
      yq.push_back(yn);
      eq.push_back(ei);
      rise = req & ~m_prev;
      m_prev = req;
      for (int m = 0; m < 2; m++) begin
        clr = (m_valid[m] && ack) ? (8'b1 << m_code[m]) : 8'b0;
        m_ovf[m] = (rise & m_pend[m] & ~clr) != 8'b0;
        m_gs[m] = !(en && m_pend[m] != 8'b0);
        m_eo[m] = !(en && m_pend[m] == 8'b0);
        if (!m_valid[m] && en && m_pend[m] != 8'b0) begin
          m_code[m] = pick(m_pend[m], m == 1);
          m_valid[m] = 1'b1;
        end else if (m_valid[m] && ack) m_valid[m] = 1'b0;
        m_pend[m] = (m_pend[m] & ~clr) | rise;
      end
    end
  end

  always @(negedge clk) if (!rst) begin
    for (int m = 0; m < 2; m++) begin
      chk($sformatf("code%0d", m), 8'(code[m]), 8'(m_code[m]));
      chk($sformatf("valid%0d", m), 8'(valid[m]), 8'(m_valid[m]));
      chk($sformatf("gs_n%0d", m), 8'(gs[m]), 8'(m_gs[m]));
      chk($sformatf("eo_n%0d", m), 8'(eo[m]), 8'(m_eo[m]));
      chk($sformatf("ovf%0d", m), 8'(ovf[m]), 8'(m_ovf[m]));
      if (valid[m] && !pv[m]) seen[m].push_back(int'(code[m]));
      pv[m] = valid[m];
    end
    if (ovf[1]) ovf_cnt++;
  end

  initial begin
    cyc(3);
    rst = 1'b0;
    chk("rst_valid", 8'(valid[1]), 8'd0);
    chk("rst_gs", 8'(gs[1]), 8'd1);
    chk("rst_eo", 8'(eo[1]), 8'd1);
    ei = 1'b0;
    cyc(4);
    chk("idle_eo", 8'(eo[1]), 8'd0);
    yn = 8'hFB;
    cyc(3);
    chk("lat_early", 8'(valid[1]), 8'd0);
    cyc(1);
    chk("lat_valid", 8'(valid[1]), 8'd1);
    chk("single_code", 8'(code[1]), 8'd2);
    chk("single_gs", 8'(gs[1]), 8'd0);
    ack_pulse();
    chk("ack_drop", 8'(valid[1]), 8'd0);
    cyc(1);
    chk("ack_eo", 8'(eo[1]), 8'd0);
    yn = 8'hFF;
    cyc(4);
    seen[0].delete();
    seen[1].delete();
    ack = 1'b1;
    yn = 8'h9D;
    cyc(20);
    ack = 1'b0;
    yn = 8'hFF;
    cyc(4);
    chk("hi_n", 8'(seen[1].size()), 8'd3);
    chk("lo_n", 8'(seen[0].size()), 8'd3);
    if (seen[1].size() == 3 && seen[0].size() == 3) begin
      chk("hi_0", 8'(seen[1][0]), 8'd6); chk("hi_1", 8'(seen[1][1]), 8'd5); chk("hi_2", 8'(seen[1][2]), 8'd1);
      chk("lo_0", 8'(seen[0][0]), 8'd1); chk("lo_1", 8'(seen[0][1]), 8'd5); chk("lo_2", 8'(seen[0][2]), 8'd6);
    end
    yn = 8'hF7;
    cyc(6);
    cyc(10);
    yn = 8'h77;
    ei = 1'b1;
    cyc(6);
    chk("hold_code", 8'(code[1]), 8'd3);
    chk("hold_valid", 8'(valid[1]), 8'd1);
    ack_pulse();
    cyc(8);
    chk("dis_valid", 8'(valid[1]), 8'd0);
    chk("dis_gs", 8'(gs[1]), 8'd1);
    chk("dis_eo", 8'(eo[1]), 8'd1);
    ei = 1'b0;
    cyc(5);
    chk("en_valid", 8'(valid[1]), 8'd1);
    chk("en_code", 8'(code[1]), 8'd7);
    ack_pulse();
    yn = 8'hFF;
    cyc(6);
    ovf_cnt = 0;
    seen[1].delete();
    yn = 8'hEF; cyc(1);
    yn = 8'hFF; cyc(1);
    yn = 8'hEF; cyc(1);
    yn = 8'hFF; cyc(8);
    ack_pulse();
    cyc(6);
    chk("ovf_once", 8'(ovf_cnt), 8'd1);
    chk("ovf_pres", 8'(seen[1].size()), 8'd1);
    yn = 8'hEF; cyc(6);
    yn = 8'hFF; cyc(3);
    ovf_cnt = 0;
    yn = 8'hEF;
    cyc(2);
    ack_pulse();
    cyc(3);
    chk("coll_ovf", 8'(ovf_cnt), 8'd0);
    chk("coll_valid", 8'(valid[1]), 8'd1);
    chk("coll_code", 8'(code[1]), 8'd4);
    ack_pulse();
    yn = 8'hFF;
    cyc(4);
    seen[0].delete();
    yn = 8'hFE;
    cyc(6);
    ack_pulse();
    cyc(10);
    chk("level_once", 8'(seen[0].size()), 8'd1);
    chk("level_idle", 8'(valid[0]), 8'd0);
    yn = 8'hFF;
    cyc(4);
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 3) == 0) yn = 8'($urandom);
      ei = ($urandom_range(0, 9) == 0) ? ~ei : ei;
      ack = ($urandom_range(0, 2) == 0);
      cyc(1);
    end
    ack = 1'b0;
    ei = 1'b0;
    yn = 8'hFF;
    cyc(4);
    yn = 8'hDF;
    cyc(6);
    chk("pre_rst_valid", 8'(valid[1]), 8'd1);
    #3 rst = 1'b1;
    #1;
    chk("arst_valid", 8'(valid[1]), 8'd0);
    chk("arst_code", 8'(code[1]), 8'd0);
    chk("arst_gs", 8'(gs[1]), 8'd1);
    chk("arst_eo", 8'(eo[1]), 8'd1);
    yn = 8'hFF;
    cyc(2);
    rst = 1'b0;
    cyc(8);
    chk("post_rst_valid", 8'(valid[1]), 8'd0);
    chk("post_rst_eo", 8'(eo[1]), 8'd0);
    $display("[TB] %0d tests run, %0d failed", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/irq_encoder_148.md
Name: irq_encoder_148

Overview:
- Clocked 8-to-3 priority encoder (74148-style), the encoding counterpart of the team's 3-to-8 decoder.
- Takes eight active-low request lines in the same format the decoder drives (yn, bit k low = line k active).
- Synchronizes and edge-captures the requests into a pending register, then presents the highest-priority pending index as a 3-bit code with a valid/ack handshake.
- Drives 74148-style group-select and enable-out status for cascading.

Parameters:
SYNC_STAGES, 2, synchronizer depth on yn_i and ei_n_i; legal 2..4.
PRIO_HIGH, 1, 1 = bit 7 highest priority (74148 order); 0 = bit 0 highest.

Ports:
clk_i  input  1  clock; all flops on rising edge
rst_i  input  1  asynchronous, active-high reset
yn_i  input  8  request lines, active-low, asynchronous to clk_i
ei_n_i  input  1  enable input, active-low, asynchronous
ack_i  input  1  consumer acknowledge, synchronous
code_o  output  3  encoded index of presented request
valid_o  output  1  code_o is valid; held until acknowledged
gs_n_o  output  1  group select, active-low: enabled and any request pending
eo_n_o  output  1  enable out, active-low: enabled and nothing pending
ovf_o  output  1  one-cycle pulse: new request on an already-pending line

Behaviour:
- Reset (rst_i high, async):
  - Synchronizer flops = 1 (inactive); pend = 0; state = IDLE.
  - code_o = 0, valid_o = 0, gs_n_o = 1, eo_n_o = 1, ovf_o = 0.
- Synchronizer: yn_i and ei_n_i each pass through SYNC_STAGES flops. Define req_s = ~yn_sync and en_s = ~ei_sync.
- Edge capture:
  - Register prev_req = req_s. rise = req_s & ~prev_req (high-to-low on yn_i).
  - pend[k] is set on rise[k].
  - pend[k] is cleared on the handshake for code k.
  - If set and clear of the same bit coincide, set wins.
  - Level-only requests (held low, no new edge) are not re-pended after clearing.
- ovf_o: registered pulse, high for one cycle when rise[k] and pend[k] is already 1 and not being cleared that cycle. Pending requests are not counted.
- FSM, two states:
  - IDLE: valid_o = 0; ack_i ignored. If en_s and pend != 0: register code_o = highest-priority set bit of pend (per PRIO_HIGH), set valid_o = 1, go to PRESENT.
  - PRESENT: code_o and valid_o are held stable regardless of new pends, en_s changes or higher-priority arrivals; no retraction. On ack_i = 1: clear pend[code_o], valid_o = 0 next cycle, go to IDLE.
  - Minimum one IDLE cycle between codes, so back-to-back codes show valid_o low for exactly 1 cycle.
- Latency: counting the first edge that samples yn_i low as edge 1, valid_o is high after edge SYNC_STAGES+2. That is 4 cycles at the default.
- Enable: en_s = 0 blocks IDLE→PRESENT only. Edges are still captured into pend while disabled; they present once enabled.
- Status outputs (registered):
  - gs_n_o = ~(en_s & |pend).
  - eo_n_o = ~(en_s & ~|pend).
  - Disabled gives gs_n_o = eo_n_o = 1.
- Reset mid-handshake: valid_o drops immediately (async) and all pending requests are lost.
- Widths: code_o is exactly 3 bits; pend is 8 bits; no arithmetic overflow paths.

Test Plan:
- Reset: assert rst_i mid-PRESENT → valid_o, code_o, pend go to 0, gs_n_o = eo_n_o = 1 without waiting for a clock edge.
- Single request: ei_n_i = 0, yn_i = 8'hFF → 8'hFB (bit 2) → valid_o high after edge 4, code_o = 3'd2, gs_n_o = 0. Assert ack_i one cycle → valid_o low next cycle, eo_n_o = 0.
- Priority, PRIO_HIGH = 1: falling edges on bits 1, 5, 6 in the same cycle → codes presented 6, 5, 1 in order. Each pair is separated by exactly one valid_o-low cycle with ack_i tied high. Repeat with PRIO_HIGH = 0 → order 1, 5, 6.
- Hold stability: code 3 in PRESENT, ack_i held low 10 cycles, then bit 7 edge and ei_n_i high → code_o stays 3 and valid_o stays 1. After ack, code 7 is not presented until ei_n_i returns low.
- Overflow and collision:
  - Bit 4 edge, release, second edge before ack → ovf_o pulses once, code 4 presented once.
  - New bit-4 edge in the same cycle as ack of code 4 → no ovf_o pulse, bit 4 re-presented.
- Level request: yn_i bit 0 held low across ack → code 0 presented only once.
